// File: rtl/pipe_defs.sv
// Shared definitions for the back half of the pipeline.
//   - forwarding-bundle field positions and width
//   - register-zero constant
//   - slot_t: contents of one pipeline slot (EX/MEM or MEM/WB register)
//   - helpers deciding whether a slot writes the register file and
//     whether a destination collides with the ID-stage sources
package pipe_defs;

    localparam int DATA_W       = 32;
    localparam int RADDR_W      = 5;
    localparam int FWD_W        = 38;
    localparam int FWD_DATA_LSB = 0;
    localparam int FWD_DATA_MSB = 31;
    localparam int FWD_ADDR_LSB = 32;
    localparam int FWD_ADDR_MSB = 36;
    localparam int FWD_WR       = 37;

    localparam logic [RADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  result;
        logic [RADDR_W-1:0] addr;
        logic               reg_wr;
        logic               mem_to_reg;
        logic               mem_wr;
        logic [DATA_W-1:0]  store_data;
    } slot_t;

    // Register 0 is hard-wired, so a write to it is not a write at all.
    function automatic logic slot_writes(input slot_t s);
        return s.valid & s.reg_wr & (s.addr != REG_ZERO);
    endfunction

    function automatic logic src_match(input logic [RADDR_W-1:0] dst,
                                       input logic [RADDR_W-1:0] rs,
                                       input logic [RADDR_W-1:0] rt,
                                       input logic               uses_rt);
        return (dst == rs) | ((dst == rt) & uses_rt);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot register (EX/MEM or MEM/WB).
// Ports:
//   clk     in  : pipeline clock, rising edge
//   rst_n   in  : asynchronous active-low reset, clears every field
//   slot_d  in  : slot contents to capture
//   slot_q  out : registered slot contents
module pipe_slot
    import pipe_defs::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  slot_t slot_d,
    output slot_t slot_q
);

    // All fields clear, not just valid, so every derived output reads 0
    // while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) slot_q <= '0;
        else        slot_q <= slot_d;
    end

endmodule

// File: rtl/result_pipe.sv
// Back half of the five-stage pipeline: EX/MEM and MEM/WB registers,
// data-memory drive, register-file write port, forwarding bundles and
// load-use / RAW stall detection.
// Build option: RESULT_PIPE_FWD_EN
//   defined   -> bundles carry write-valid, stall covers loads only
//   undefined -> bundle bit 37 tied 0, stall on any writing dependency
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   ex_valid, ex_alu_res, ex_wr_addr: EX instruction result/destination
//   ex_regWr, ex_memToReg, ex_memWr : EX control bits
//   ex_store_data                   : store data (rt value)
//   id_rs, id_rt, id_uses_rt        : ID source registers
//   mem_addr, mem_wdata, mem_wr,
//   mem_rd, mem_rdata               : data memory port
//   ALUres_ex, ALUres_mem           : forwarding bundles {wr, addr, data}
//   dw, wr_addr, wr_en              : register-file write port
//   stall                           : hold ID, bubble EX next cycle
module result_pipe
    import pipe_defs::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    input  logic [DATA_W-1:0]  ex_alu_res,
    input  logic [RADDR_W-1:0] ex_wr_addr,
    input  logic               ex_regWr,
    input  logic               ex_memToReg,
    input  logic               ex_memWr,
    input  logic [DATA_W-1:0]  ex_store_data,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic               id_uses_rt,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               mem_wr,
    output logic               mem_rd,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [FWD_W-1:0]   ALUres_ex,
    output logic [FWD_W-1:0]   ALUres_mem,
    output logic [DATA_W-1:0]  dw,
    output logic [RADDR_W-1:0] wr_addr,
    output logic               wr_en,
    output logic               stall
);

    slot_t ex_slot;
    slot_t mem_d, mem_q;
    slot_t wb_d,  wb_q;
    logic  wb_unused;

    always_comb begin
        ex_slot            = '0;
        ex_slot.valid      = ex_valid;
        ex_slot.result     = ex_alu_res;
        ex_slot.addr       = ex_wr_addr;
        ex_slot.reg_wr     = ex_regWr;
        ex_slot.mem_to_reg = ex_memToReg;
        ex_slot.mem_wr     = ex_memWr;
        ex_slot.store_data = ex_store_data;
        // Bubbles enter MEM fully zeroed so stale control bits never
        // reach the memory strobes or the dw mux.
        mem_d = ex_slot.valid ? ex_slot : '0;
        wb_d  = mem_q;
    end

    pipe_slot u_mem_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .slot_d (mem_d),
        .slot_q (mem_q)
    );

    pipe_slot u_wb_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .slot_d (wb_d),
        .slot_q (wb_q)
    );

    // WB never touches memory; its store fields are carried but unused.
    assign wb_unused = ^{wb_q.store_data, wb_q.mem_wr};

    always_comb begin
        ALUres_ex  = '0;
        ALUres_mem = '0;
        ALUres_ex[FWD_DATA_MSB:FWD_DATA_LSB]  = ex_slot.result;
        ALUres_ex[FWD_ADDR_MSB:FWD_ADDR_LSB]  = ex_slot.addr;
        ALUres_mem[FWD_DATA_MSB:FWD_DATA_LSB] = mem_q.result;
        ALUres_mem[FWD_ADDR_MSB:FWD_ADDR_LSB] = mem_q.addr;
`ifdef RESULT_PIPE_FWD_EN
        // Load data only exists after MEM, so loads are never forwarded.
        ALUres_ex[FWD_WR]  = slot_writes(ex_slot) & ~ex_slot.mem_to_reg;
        ALUres_mem[FWD_WR] = slot_writes(mem_q) & ~mem_q.mem_to_reg;
`endif
        // EX bundle is combinational from the inputs; force it quiet in reset.
        if (!rst_n) ALUres_ex = '0;
    end

    always_comb begin
        mem_addr  = mem_q.result;
        mem_wdata = mem_q.store_data;
        mem_wr    = mem_q.valid & mem_q.mem_wr;
        mem_rd    = mem_q.valid & mem_q.mem_to_reg;
        wr_en     = slot_writes(wb_q);
        wr_addr   = wb_q.addr;
        dw        = wb_q.mem_to_reg ? mem_rdata : wb_q.result;
    end

    logic hz_ex, hz_mem, hz_wb;

    always_comb begin
        hz_ex  = slot_writes(ex_slot) & src_match(ex_slot.addr, id_rs, id_rt, id_uses_rt);
        hz_mem = slot_writes(mem_q)   & src_match(mem_q.addr,   id_rs, id_rt, id_uses_rt);
        hz_wb  = slot_writes(wb_q)    & src_match(wb_q.addr,    id_rs, id_rt, id_uses_rt);
`ifdef RESULT_PIPE_FWD_EN
        hz_ex  = hz_ex  & ex_slot.mem_to_reg;
        hz_mem = hz_mem & mem_q.mem_to_reg;
        hz_wb  = hz_wb  & wb_q.mem_to_reg;
`endif
        stall = rst_n & (hz_ex | hz_mem | hz_wb);
    end

endmodule
